// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its shared-memory datapath.
// Latency: pure wiring; instruction fields and ALU flags in, enables and selects out.
// Backpressure: none; the datapath acts on every control word it is given.
interface multicycle_controller_if #(
  parameter int ALUCTL_W = 2
);
  logic [19:0]         instr;       // instr[31:12]: cond, op, funct, Rn, Rd
  logic [3:0]          ALUFlags;    // NZCV from the ALU
  logic                pcWrite;
  logic                adrSrc;
  logic                memWrite;
  logic                IRWrite;
  logic [1:0]          resultSrc;
  logic                ALUSrcA;
  logic [1:0]          ALUSrcB;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [1:0]          immSrc;
  logic [1:0]          regSrc;
  logic                regWrite;
  logic [3:0]          state_o;

  // Controller side: consumes instruction/flags, drives the datapath controls.
  modport master (
    input  instr, ALUFlags,
    output pcWrite, adrSrc, memWrite, IRWrite, resultSrc, ALUSrcA, ALUSrcB,
           ALUControl, immSrc, regSrc, regWrite, state_o
  );

  // Datapath side: the mirror image.
  modport slave (
    output instr, ALUFlags,
    input  pcWrite, adrSrc, memWrite, IRWrite, resultSrc, ALUSrcA, ALUSrcB,
           ALUControl, immSrc, regSrc, regWrite, state_o
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore FSM sequencing, NZCV flag register, condition check.
// Latency: controls are valid in the cycle of their state; 2 to 5 cycles per instruction.
// Backpressure: none; the FSM advances every clock and the datapath must keep pace.
module multicycle_controller #(
  parameter int ALUCTL_W = 2,
  parameter bit EN_CMP   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_EXECI  = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
  localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
  localparam logic [ALUCTL_W-1:0] ALU_ORR = ALUCTL_W'(3);
  localparam logic [ALUCTL_W-1:0] ALU_EOR = ALUCTL_W'(4);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.instr[19:16];
  assign op        = bus.instr[15:14];
  assign funct     = bus.instr[13:8];
  assign rd        = bus.instr[3:0];
  assign unused_rn = ^bus.instr[7:4];

  logic [3:0]          state;
  logic [3:0]          state_nxt;
  logic [3:0]          flags;      // {N, Z, C, V}
  logic                cond_ex;
  logic [ALUCTL_W-1:0] alu_code;
  logic [1:0]          flag_w_raw;
  logic [1:0]          flag_w;
  logic                no_write;
  logic                is_cmp;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  // Next-state sequencing; unused encodings fall back to FETCH.
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          2'b00:   state_nxt = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_nxt = S_MEMADR;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = S_MEMWB;
      S_EXECR:  state_nxt = S_ALUWB;
      S_EXECI:  state_nxt = S_ALUWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Data-processing decode: ALU op, which flag groups update, and write suppression.
  always_comb begin
    alu_code   = ALU_ADD;
    flag_w_raw = 2'b00;
    no_write   = 1'b1;
    is_cmp     = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_code = ALU_ADD; flag_w_raw = 2'b11; no_write = 1'b0; end
      4'b0010: begin alu_code = ALU_SUB; flag_w_raw = 2'b11; no_write = 1'b0; end
      4'b0000: begin alu_code = ALU_AND; flag_w_raw = 2'b10; no_write = 1'b0; end
      4'b1100: begin alu_code = ALU_ORR; flag_w_raw = 2'b10; no_write = 1'b0; end
      4'b0001: begin
        if (ALUCTL_W >= 3) begin
          alu_code = ALU_EOR; flag_w_raw = 2'b10; no_write = 1'b0;
        end
      end
      4'b1010: begin
        if (EN_CMP) begin
          alu_code = ALU_SUB; flag_w_raw = 2'b11; is_cmp = 1'b1;
        end
      end
      default: ;
    endcase
    // CMP exists only to set flags, so it ignores the S bit.
    flag_w = is_cmp ? flag_w_raw : (flag_w_raw & {2{funct[0]}});
  end

  // Flag register, loaded at the end of the execute cycle of a passing instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if ((state == S_EXECR || state == S_EXECI) && cond_ex) begin
      if (flag_w[1]) flags[3:2] <= bus.ALUFlags[3:2];
      if (flag_w[0]) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  // Condition evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags[2];
      4'b0001: cond_ex = ~flags[2];
      4'b0010: cond_ex = flags[1];
      4'b0011: cond_ex = ~flags[1];
      4'b0100: cond_ex = flags[3];
      4'b0101: cond_ex = ~flags[3];
      4'b0110: cond_ex = flags[0];
      4'b0111: cond_ex = ~flags[0];
      4'b1000: cond_ex = flags[1] & ~flags[2];
      4'b1001: cond_ex = ~flags[1] | flags[2];
      4'b1010: cond_ex = (flags[3] == flags[0]);
      4'b1011: cond_ex = (flags[3] != flags[0]);
      4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
      4'b1101: cond_ex = flags[2] | (flags[3] != flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  logic                pcw;
  logic                regw;
  logic                memw;
  logic                irw;
  logic                adr;
  logic [1:0]          res;
  logic                srca;
  logic [1:0]          srcb;
  logic [ALUCTL_W-1:0] aluc;

  // Moore output decode; writes are qualified by the condition where the ISA requires.
  always_comb begin
    pcw  = 1'b0;
    regw = 1'b0;
    memw = 1'b0;
    irw  = 1'b0;
    adr  = 1'b0;
    res  = 2'b00;
    srca = 1'b0;
    srcb = 2'b00;
    aluc = ALU_ADD;
    case (state)
      S_FETCH: begin
        irw = 1'b1; pcw = 1'b1; srca = 1'b1; srcb = 2'b10; res = 2'b10;
      end
      S_DECODE: begin
        srca = 1'b1; srcb = 2'b10; res = 2'b10;
      end
      S_MEMADR: begin
        srcb = 2'b01;
        aluc = funct[3] ? ALU_ADD : ALU_SUB;
      end
      S_MEMRD: adr = 1'b1;
      S_MEMWR: begin
        adr  = 1'b1;
        memw = cond_ex;
      end
      S_MEMWB: begin
        res  = 2'b01;
        regw = cond_ex;
        pcw  = cond_ex & (rd == 4'hF);
      end
      S_EXECR: aluc = alu_code;
      S_EXECI: begin
        srcb = 2'b01;
        aluc = alu_code;
      end
      S_ALUWB: begin
        regw = cond_ex & ~no_write;
        pcw  = cond_ex & ~no_write & (rd == 4'hF);
      end
      S_BRANCH: begin
        srcb = 2'b01; res = 2'b10;
        pcw  = cond_ex;
      end
      default: ;
    endcase
  end

  // Enables are killed combinationally so nothing is written while reset is high.
  assign bus.pcWrite    = pcw  & ~reset;
  assign bus.IRWrite    = irw  & ~reset;
  assign bus.memWrite   = memw & ~reset;
  assign bus.regWrite   = regw & ~reset;
  assign bus.adrSrc     = adr;
  assign bus.resultSrc  = res;
  assign bus.ALUSrcA    = srca;
  assign bus.ALUSrcB    = srcb;
  assign bus.ALUControl = aluc;
  assign bus.immSrc     = op;
  assign bus.regSrc     = {op == 2'b01, op == 2'b10};
  assign bus.state_o    = state;

endmodule
